// File: rtl/bus_demux3_if.sv
// Core-side request/response and shared target-side bus of the 3-way data-memory demux.
// The demux binds to the slave modport; the core and targets together form the master view.
interface bus_demux3_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [DATA_W-1:0] req_wdata;
  logic [3:0]        req_wstrb;

  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  logic [2:0]          t_valid;
  logic [2:0]          t_ready;
  logic [ADDR_W-1:0]   t_addr;
  logic                t_we;
  logic [DATA_W-1:0]   t_wdata;
  logic [3:0]          t_wstrb;
  logic [2:0]          t_resp_valid;
  logic [3*DATA_W-1:0] t_rdata;

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output t_valid, t_addr, t_we, t_wdata, t_wstrb,
    input  t_ready, t_resp_valid, t_rdata
  );

  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_wstrb,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  t_valid, t_addr, t_we, t_wdata, t_wstrb,
    output t_ready, t_resp_valid, t_rdata
  );
endinterface

// File: rtl/bus_demux3.sv
// Routes one data-memory request to ROM/RAM/MMIO by address decode, one transaction in flight.
// Optional response timeout enabled with `define BUS_DEMUX3_TIMEOUT_EN.
module bus_demux3 #(
  parameter int              ADDR_W         = 32,
  parameter int              DATA_W         = 32,
  parameter logic [ADDR_W-1:0] T0_BASE      = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] T0_MASK      = 32'hFFFF_0000,
  parameter logic [ADDR_W-1:0] T1_BASE      = 32'h1000_0000,
  parameter logic [ADDR_W-1:0] T1_MASK      = 32'hFFFF_0000,
  parameter logic [ADDR_W-1:0] T2_BASE      = 32'h2000_0000,
  parameter logic [ADDR_W-1:0] T2_MASK      = 32'hFFFF_F000,
  parameter logic [DATA_W-1:0] ERR_RDATA    = 32'h0000_CAFE,
  parameter int              TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  bus_demux3_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ERR   = 2'd3
  } state_e;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cfg
    $error("bus_demux3: TIMEOUT_CYCLES must be at least 1");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [1:0]        sel_q, sel_d;

  logic [1:0]        dec_sel_s;
  logic              dec_hit_s;
  logic              sel_ready_s;
  logic              sel_resp_s;
  logic [DATA_W-1:0] sel_rdata_s;
  logic [2:0]        sel_onehot_s;
  logic              timeout_s;

`ifdef BUS_DEMUX3_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Timeout counter: zero on ISSUE entry, counts every ISSUE/WAIT cycle.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_s = 1'b0;
    if ((state_q == S_ISSUE) || (state_q == S_WAIT)) begin
      cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      timeout_s = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Address decode with ROM > RAM > MMIO priority on overlap.
  always_comb begin
    dec_hit_s = 1'b1;
    dec_sel_s = 2'd0;
    if ((bus.req_addr & T0_MASK) == T0_BASE) begin
      dec_sel_s = 2'd0;
    end else if ((bus.req_addr & T1_MASK) == T1_BASE) begin
      dec_sel_s = 2'd1;
    end else if ((bus.req_addr & T2_MASK) == T2_BASE) begin
      dec_sel_s = 2'd2;
    end else begin
      dec_hit_s = 1'b0;
    end
  end

  // Pick the latched target's handshake and read data.
  always_comb begin
    case (sel_q)
      2'd0: begin
        sel_ready_s  = bus.t_ready[0];
        sel_resp_s   = bus.t_resp_valid[0];
        sel_rdata_s  = bus.t_rdata[0*DATA_W +: DATA_W];
        sel_onehot_s = 3'b001;
      end
      2'd1: begin
        sel_ready_s  = bus.t_ready[1];
        sel_resp_s   = bus.t_resp_valid[1];
        sel_rdata_s  = bus.t_rdata[1*DATA_W +: DATA_W];
        sel_onehot_s = 3'b010;
      end
      2'd2: begin
        sel_ready_s  = bus.t_ready[2];
        sel_resp_s   = bus.t_resp_valid[2];
        sel_rdata_s  = bus.t_rdata[2*DATA_W +: DATA_W];
        sel_onehot_s = 3'b100;
      end
      default: begin
        sel_ready_s  = 1'b0;
        sel_resp_s   = 1'b0;
        sel_rdata_s  = {DATA_W{1'b0}};
        sel_onehot_s = 3'b000;
      end
    endcase
  end

  // Next-state and request-latch logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          we_d    = bus.req_we;
          wdata_d = bus.req_wdata;
          wstrb_d = bus.req_wstrb;
          sel_d   = dec_sel_s;
          state_d = dec_hit_s ? S_ISSUE : S_ERR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        // A same-cycle response beats both the timeout and the move to WAIT.
        if (sel_ready_s && sel_resp_s) begin
          state_d = S_IDLE;
        end else if (timeout_s) begin
          state_d = S_ERR;
        end else if (sel_ready_s) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (sel_resp_s) begin
          state_d = S_IDLE;
        end else if (timeout_s) begin
          state_d = S_ERR;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched-request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= {ADDR_W{1'b0}};
      we_q    <= 1'b0;
      wdata_q <= {DATA_W{1'b0}};
      wstrb_q <= 4'b0000;
      sel_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      sel_q   <= sel_d;
    end
  end

  // Handshake and response outputs; a reset cycle suppresses everything.
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.t_valid    = 3'b000;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = {DATA_W{1'b0}};
    bus.resp_err   = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE: bus.req_ready = 1'b1;
        S_ISSUE: begin
          bus.t_valid = sel_onehot_s;
          if (sel_ready_s && sel_resp_s) begin
            bus.resp_valid = 1'b1;
            bus.resp_rdata = sel_rdata_s;
          end else begin
            bus.resp_valid = 1'b0;
          end
        end
        S_WAIT: begin
          if (sel_resp_s) begin
            bus.resp_valid = 1'b1;
            bus.resp_rdata = sel_rdata_s;
          end else begin
            bus.resp_valid = 1'b0;
          end
        end
        S_ERR: begin
          bus.resp_valid = 1'b1;
          bus.resp_err   = 1'b1;
          bus.resp_rdata = ERR_RDATA;
        end
        default: bus.req_ready = 1'b0;
      endcase
    end else begin
      bus.req_ready = 1'b0;
    end
  end

  assign bus.t_addr  = addr_q;
  assign bus.t_we    = we_q;
  assign bus.t_wdata = wdata_q;
  assign bus.t_wstrb = wstrb_q;

endmodule
